// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-timer trap controller.
package trap_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      COOL = 2'd2
   } state_e;

   localparam logic [31:0] MCAUSE_MTI          = 32'h8000_0007;
   localparam int unsigned COOL_CYCLES         = 2;
   localparam int unsigned COOL_CNT_W          = 2;
   localparam logic [1:0]  MTVEC_MODE_VECTORED = 2'b01;
   localparam logic [31:0] MTI_VEC_OFFSET      = 32'd28;

   // Trap target: base address, plus the MTI slot offset in vectored mode.
   function automatic logic [31:0] trap_target(input logic [31:0] mtvec);
      logic [31:0] base;
      base = {mtvec[31:2], 2'b00};
      if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
         trap_target = base + MTI_VEC_OFFSET;
      end else begin
         trap_target = base;
      end
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Interrupt input register/synchronizer. Two flops when TRAP_CTRL_SYNC_EN is
// defined, otherwise a single register (only safe for a synchronous source).
module irq_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

`ifdef TRAP_CTRL_SYNC_EN
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end
`else
   logic sync_q, sync_d;

   always_comb begin
      sync_d = d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
      end
   end
`endif

   assign q = sync_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-timer interrupt / mret redirect controller with a post-redirect
// quiet period. Synchronizer depth selected by TRAP_CTRL_SYNC_EN.
module trap_ctrl
   import trap_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        irq_in,
   input  logic        irq_en,
   input  logic        mret_wb,
   input  logic        br_taken,
   input  logic        stall_id_ex,
   input  logic        ex_valid,
   input  logic [31:0] pc_if,
   input  logic [31:0] pc_ex,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush_id_ex,
   output logic        flush_ex_mem,
   output logic        csr_trap_we,
   output logic [31:0] csr_mepc_wdata,
   output logic [31:0] csr_mcause_wdata,
   output logic        csr_mie_clr,
   output logic        csr_mie_set,
   output logic        irq_ack,
   output logic        busy
);

   state_e                  state_q, state_d;
   logic [COOL_CNT_W-1:0]   cool_cnt_q, cool_cnt_d;
   logic                    irq_s;
   logic                    pending;
   logic                    boundary_ok;

   irq_sync u_irq_sync (
      .clk (clk),
      .rst (rst),
      .d   (irq_in),
      .q   (irq_s)
   );

   assign pending     = irq_s & irq_en;
   assign boundary_ok = ~br_taken & ~stall_id_ex & ~mret_wb;
   assign busy        = (state_q != IDLE);

   // Next state and Mealy redirect outputs; reset suppresses any event.
   always_comb begin
      state_d          = state_q;
      cool_cnt_d       = cool_cnt_q;
      redirect         = 1'b0;
      redirect_pc      = 32'h0;
      flush_id_ex      = 1'b0;
      flush_ex_mem     = 1'b0;
      csr_trap_we      = 1'b0;
      csr_mepc_wdata   = 32'h0;
      csr_mcause_wdata = 32'h0;
      csr_mie_clr      = 1'b0;
      csr_mie_set      = 1'b0;
      irq_ack          = 1'b0;

      unique case (state_q)
         IDLE, WAIT: begin
            if (!rst) begin
               if (mret_wb) begin
                  redirect     = 1'b1;
                  redirect_pc  = mepc;
                  flush_id_ex  = 1'b1;
                  flush_ex_mem = 1'b1;
                  csr_mie_set  = 1'b1;
                  state_d      = COOL;
                  cool_cnt_d   = '0;
               end else if (pending && boundary_ok) begin
                  redirect         = 1'b1;
                  redirect_pc      = trap_target(mtvec);
                  flush_id_ex      = 1'b1;
                  flush_ex_mem     = 1'b1;
                  csr_trap_we      = 1'b1;
                  csr_mepc_wdata   = ex_valid ? pc_ex : pc_if;
                  csr_mcause_wdata = MCAUSE_MTI;
                  csr_mie_clr      = 1'b1;
                  irq_ack          = 1'b1;
                  state_d          = COOL;
                  cool_cnt_d       = '0;
               end else if (pending) begin
                  state_d = WAIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         COOL: begin
            if (cool_cnt_q == COOL_CNT_W'(COOL_CYCLES - 1)) begin
               state_d    = IDLE;
               cool_cnt_d = '0;
            end else begin
               cool_cnt_d = cool_cnt_q + COOL_CNT_W'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            cool_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cool_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cool_cnt_q <= cool_cnt_d;
      end
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first: clk in 1 (sole clock); rst in 1 (synchronous, active-high reset).
REQ-002 SHALL have these inputs:
- irq_in in 1: asynchronous, level-sensitive machine-timer interrupt.
- irq_en in 1: mstatus.MIE & mie.MTIE from the CSR file.
- mret_wb in 1: mret in the memory/writeback stage.
- br_taken in 1: branch taken in the execute stage.
- stall_id_ex in 1: hazard-unit stall.
- ex_valid in 1: a non-bubble instruction is in execute.
- pc_if in 32: fetch PC.
- pc_ex in 32: execute-stage PC.
- mtvec in 32 and mepc in 32: CSR values.
REQ-003 SHALL have these outputs:
- redirect out 1: the PC mux selects redirect_pc.
- redirect_pc out 32.
- flush_id_ex out 1 and flush_ex_mem out 1: squash the fetch->ex and ex->mem registers.
- csr_trap_we out 1 and csr_mepc_wdata out 32: write mepc.
- csr_mcause_wdata out 32: write mcause.
- csr_mie_clr out 1 and csr_mie_set out 1.
- irq_ack out 1.
- busy out 1: state != IDLE.

Function
REQ-004 SHALL qualify the interrupt: pending = irq_s & irq_en, where irq_s is the synchronized irq_in.
REQ-005 SHALL implement a three-state FSM:
- IDLE: no activity.
- WAIT: pending but blocked.
- COOL: 2-cycle quiet period after any redirect.
REQ-006 SHALL define boundary_ok = ~br_taken & ~stall_id_ex & ~mret_wb.
REQ-007 In IDLE or WAIT, mret_wb=1 SHALL, in the same cycle (Mealy):
- assert redirect=1, redirect_pc=mepc, flush_id_ex=1, flush_ex_mem=1 and csr_mie_set=1;
- go to COOL.
REQ-008 In IDLE or WAIT, pending & boundary_ok SHALL, in the same cycle:
- assert redirect=1, flush_id_ex=1, flush_ex_mem=1, csr_trap_we=1, csr_mie_clr=1 and irq_ack=1;
- drive csr_mepc_wdata = ex_valid ? pc_ex : pc_if, and csr_mcause_wdata = 32'h8000_0007;
- go to COOL.
REQ-009 SHALL compute redirect_pc for a trap by mtvec mode:
- mtvec[1:0]==2'b01 (vectored): {mtvec[31:2],2'b00} + 32'd28, modulo 2^32.
- any other mode: {mtvec[31:2],2'b00}.
REQ-010 SHALL give mret priority over an interrupt in the same cycle; the interrupt stays pending and is evaluated after COOL.
REQ-011 In IDLE, pending & ~boundary_ok with no mret SHALL move to WAIT with no output asserted.
REQ-012 In WAIT, pending falling to 0 with no mret SHALL return to IDLE without a trap.
REQ-013 COOL SHALL:
- last exactly 2 cycles, counted by a 2-bit counter;
- ignore pending and mret_wb;
- assert no output except busy=1;
- then return to IDLE.
REQ-014 SHALL hold every output other than busy at 0 whenever no REQ-007/REQ-008 event fires; redirect SHALL never last more than 1 cycle per event.
REQ-015 SHALL not stall the pipeline; the instruction in memory/writeback always commits.

Reset
REQ-016 On rst=1 at a clk edge, SHALL set state=IDLE, the cool counter to 0 and the synchronizer flops to 0.
REQ-017 With state=IDLE and irq_s=0 after reset, all outputs SHALL be 0.
REQ-018 Reset asserted mid-WAIT or mid-COOL SHALL abandon the sequence with no trap pulse, and SHALL take priority over any concurrent event.

Configuration
REQ-019 With TRAP_CTRL_SYNC_EN defined, irq_s SHALL be irq_in through a 2-flop synchronizer, giving 2 cycles of latency before pending.
REQ-020 Without TRAP_CTRL_SYNC_EN, irq_s SHALL be irq_in registered once (1-cycle latency); this is legal only for a synchronous irq_in.

Structure
REQ-021 SHALL place in shared package trap_pkg:
- the state enum (IDLE, WAIT, COOL);
- MCAUSE_MTI = 32'h8000_0007;
- COOL_CYCLES = 2;
- MTVEC_MODE_VECTORED = 2'b01.
REQ-022 SHALL implement the synchronizer as sub-module irq_sync (clk, rst, d, q); its depth is selected by TRAP_CTRL_SYNC_EN.

Verification
REQ-023 The bench SHALL cover these scenarios (sync enabled):
- Basic trap: irq_en=1, mtvec=32'h0000_0100, ex_valid=1, pc_ex=32'h0000_0040; raise irq_in -> 2 cycles later a 1-cycle pulse with redirect_pc=0x100, csr_mepc_wdata=0x40, csr_mcause_wdata=0x8000_0007, then busy for 2 cycles.
- Vectored mode: mtvec=32'h0000_0201 -> redirect_pc=0x21C.
- Blocked by branch: br_taken=1 for 1 cycle while pending -> state WAIT, trap fires the next cycle with ex_valid=0 and mepc=pc_if.
- mret vs interrupt: mret_wb and pending in the same cycle, mepc=0x80 -> redirect_pc=0x80 with csr_mie_set=1; the trap fires 3 cycles later if still pending.
- Interrupt withdrawn: irq_en drops while in WAIT -> back to IDLE, no pulse; rst during COOL -> IDLE next cycle, all outputs 0.
